// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit (MULTU/DIVU) for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle through one shared adder. busy stalls the pipeline while the
// operation runs. HI/LO change only on the final write.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             op_q;
    // opnd: addend (multiplicand) or divisor. work: multiplier bits shifting
    // out and low product bits shifting in, or dividend bits out and
    // quotient bits in. acc: high product half or partial remainder.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] acc;

    logic [WIDTH+1:0] add_x;
    logic [WIDTH+1:0] add_y;
    logic             add_cin;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] work_nxt;
    logic             dz_start;

    assign dz_start = op && (b == {WIDTH{1'b0}});

    // Shared adder: acc + opnd for multiply, {acc,msb} - opnd for divide
    always_comb begin
        add_x    = {(WIDTH+2){1'b0}};
        add_y    = {(WIDTH+2){1'b0}};
        add_cin  = 1'b0;
        acc_nxt  = acc;
        work_nxt = work;
        if (op_q == 1'b0) begin
            add_x = {2'b00, acc};
            if (work[0]) begin
                add_y = {2'b00, opnd};
            end else begin
                add_y = {(WIDTH+2){1'b0}};
            end
        end else begin
            add_x   = {1'b0, acc, work[WIDTH-1]};
            add_y   = ~{2'b00, opnd};
            add_cin = 1'b1;
        end
        sum = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};
        if (op_q == 1'b0) begin
            // (WIDTH+1)-bit sum keeps the carry, then shift product right
            acc_nxt  = sum[WIDTH:1];
            work_nxt = {sum[0], work[WIDTH-1:1]};
        end else if (sum[WIDTH+1]) begin
            // Negative difference: restore the shifted remainder, quotient bit 0
            acc_nxt  = add_x[WIDTH-1:0];
            work_nxt = {work[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt  = sum[WIDTH-1:0];
            work_nxt = {work[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state logic for IDLE -> RUN/FIN -> IDLE sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (dz_start) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = RUN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == FIN);
        end
    end

    // Operand capture, per-cycle iteration and final HI/LO/dz write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= {CW{1'b0}};
            op_q <= 1'b0;
            opnd <= {WIDTH{1'b0}};
            work <= {WIDTH{1'b0}};
            acc  <= {WIDTH{1'b0}};
            dz   <= 1'b0;
            hi   <= {WIDTH{1'b0}};
            lo   <= {WIDTH{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= CW'(WIDTH);
                        op_q <= op;
                        acc  <= {WIDTH{1'b0}};
                        dz   <= dz_start;
                        if (op) begin
                            opnd <= b;
                            work <= a;
                        end else begin
                            opnd <= a;
                            work <= b;
                        end
                        if (dz_start) begin
                            hi <= a;
                            lo <= {WIDTH{1'b1}};
                        end
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    work <= work_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi <= acc_nxt;
                        lo <= work_nxt;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH = 32): directed test-plan
// scenarios plus randomized operations against an arithmetic reference.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operation definition
    function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        logic [2*W-1:0] p;
        if (o == 1'b0) begin
            p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            eh = p[2*W-1:W];
            el = p[W-1:0];
            ed = 1'b0;
        end else if (y == '0) begin
            eh = x;
            el = '1;
            ed = 1'b1;
        end else begin
            eh = x % y;
            el = x / y;
            ed = 1'b0;
        end
    endfunction

    // Accept one op at E0, then observe 40 cycles (sample index i = cycle after E_i)
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int done_idx, output int busy_cnt, output int done_cnt,
                          output logic hold_ok);
        logic [W-1:0] ph, pl;
        ph = hi;
        pl = lo;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        done_idx = -1; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (done_idx < 0 && (hi !== ph || lo !== pl)) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({busy, done, dz, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL reset_asserted: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, dz, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL reset_released: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, dz, hi, lo);
        end
    endtask

    task automatic test_mul_max();
        int di, bc, dc;
        logic hk;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, di, bc, dc, hk);
        vectors++;
        if (bc != 32 || dc != 1 || di != 32) begin
            miscompares++;
            $display("FAIL mul_max_timing: got busy_cycles=%0d done_pulses=%0d done_at=%0d, want 32/1/32",
                     bc, dc, di);
        end
        vectors++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || dz !== 1'b0 || !hk) begin
            miscompares++;
            $display("FAIL mul_max_result: got hi=%h lo=%h dz=%b hold=%b, want fffffffe 00000001 0 1",
                     hi, lo, dz, hk);
        end
    endtask

    task automatic test_div();
        int di, bc, dc;
        logic hk;
        run_op(1'b1, 32'd100, 32'd7, di, bc, dc, hk);
        vectors++;
        if (di != 32 || dc != 1 || bc != 32) begin
            miscompares++;
            $display("FAIL div_timing: got done_at=%0d done_pulses=%0d busy_cycles=%0d, want 32/1/32",
                     di, dc, bc);
        end
        vectors++;
        if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0 || !hk) begin
            miscompares++;
            $display("FAIL div_result: got lo=%0d hi=%0d dz=%b hold=%b, want 14 2 0 1", lo, hi, dz, hk);
        end
    endtask

    task automatic test_div_zero();
        int di, bc, dc;
        logic hk;
        run_op(1'b1, 32'h1234_5678, 32'd0, di, bc, dc, hk);
        vectors++;
        if (bc != 0 || di != 0 || dc != 1) begin
            miscompares++;
            $display("FAIL divz_timing: got busy_cycles=%0d done_at=%0d done_pulses=%0d, want 0/0/1",
                     bc, di, dc);
        end
        vectors++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678 || dz !== 1'b1) begin
            miscompares++;
            $display("FAIL divz_result: got lo=%h hi=%h dz=%b, want ffffffff 12345678 1", lo, hi, dz);
        end
    endtask

    task automatic test_ignore_start();
        int dc, bc;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        dc = 0; bc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) dc++;
            if (i > 30 && busy) bc++;
        end
        vectors++;
        if (dc != 1 || bc != 0) begin
            miscompares++;
            $display("FAIL ignore_start_timing: got done_pulses=%0d late_busy=%0d, want 1 0", dc, bc);
        end
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd15 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start_result: got hi=%0d lo=%0d dz=%b, want 0 15 0", hi, lo, dz);
        end
    endtask

    task automatic test_async_reset();
        int di, bc, dc;
        logic hk;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd10;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, dz, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 32'd6, 32'd7, di, bc, dc, hk);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd42 || di != 32 || dc != 1) begin
            miscompares++;
            $display("FAIL after_reset_mul: got hi=%0d lo=%0d done_at=%0d pulses=%0d, want 0 42 32 1",
                     hi, lo, di, dc);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, dc;
        logic hk, b34;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h0001_0000; b = 32'h0001_0000;
        @(posedge clk);
        #1;
        a = 32'd3; b = 32'd5;
        d1 = -1; d2 = -1; dc = 0; hk = 1'b1; b34 = 1'b0;
        for (int i = 0; i < 75; i++) begin
            @(negedge clk);
            if (i == 34) b34 = busy;
            if (i == 67) start = 1'b0;
            if (done) begin
                dc++;
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (i >= 32 && i < 66 && (hi !== 32'd1 || lo !== 32'd0)) hk = 1'b0;
        end
        vectors++;
        if (d1 != 32 || d2 != 66 || !b34 || !hk) begin
            miscompares++;
            $display("FAIL b2b_timing: got done1=%0d done2=%0d busy@34=%b hold=%b, want 32 66 1 1",
                     d1, d2, b34, hk);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd15 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got hi=%0d lo=%0d busy=%b, want 0 15 0", hi, lo, busy);
        end
    endtask

    task automatic test_random();
        int di, bc, dc;
        logic hk, o, ed;
        logic [W-1:0] x, y, eh, el;
        for (int n = 0; n < 24; n++) begin
            o = $urandom_range(0, 1);
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = $urandom_range(1, 255);
                2: y = x >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            model(o, x, y, eh, el, ed);
            run_op(o, x, y, di, bc, dc, hk);
            vectors++;
            if (hi !== eh || lo !== el || dz !== ed || !hk || dc != 1 ||
                di != ((o && y == '0) ? 0 : 32)) begin
                miscompares++;
                $display("FAIL random op=%b a=%h b=%h: got hi=%h lo=%h dz=%b done_at=%0d hold=%b, want hi=%h lo=%h dz=%b",
                         o, x, y, hi, lo, dz, di, hk, eh, el, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_max();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
